// File: rtl/deal_scheduler.sv
// Round sequencer for the blackjack table: debounced-edge KEY presses drive a
// dealer/player deal order and route each card from the shared source to a hand.
module deal_scheduler #(
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 5,
  parameter int RANK_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        KEY,
  input  logic              card_ack,
  input  logic [RANK_W-1:0] card_rank,
  input  logic [5:0]        player_sum,
  input  logic [5:0]        dealer_sum,
  output logic              card_req,
  output logic [RANK_W-1:0] card_out,
  output logic              player_load,
  output logic              dealer_load,
  output logic              hands_clear,
  output logic [2:0]        phase,
  output logic [2:0]        player_cnt,
  output logic [2:0]        dealer_cnt
);

  localparam logic [5:0] STAND_SUM = 6'(DEALER_STAND);
  localparam logic [2:0] CNT_MAX   = 3'(MAX_CARDS);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_REQ, S_LOAD, S_SETTLE, S_PWAIT, S_DCHK, S_OVER
  } state_t;

  // Which card of the round the draw sub-sequence is delivering.
  typedef enum logic [2:0] {
    K_D1, K_D2, K_P1, K_P2, K_PH, K_DH
  } slot_t;

  state_t     st;
  slot_t      slot;
  logic [2:0] ks1, ks2, kprev;
  logic [2:0] press;
  logic       press_hit, press_stand, press_deal;
  logic       to_player;

  assign press       = kprev & ~ks2;
  assign press_hit   = press[0];
  assign press_stand = press[1];
  assign press_deal  = press[2];
  assign to_player   = (slot == K_P1) || (slot == K_P2) || (slot == K_PH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ks1         <= '1;
      ks2         <= '1;
      kprev       <= '1;
      st          <= S_IDLE;
      slot        <= K_D1;
      card_req    <= 1'b0;
      card_out    <= '0;
      player_load <= 1'b0;
      dealer_load <= 1'b0;
      hands_clear <= 1'b0;
      phase       <= 3'd0;
      player_cnt  <= '0;
      dealer_cnt  <= '0;
    end else begin
      ks1         <= KEY;
      ks2         <= ks1;
      kprev       <= ks2;
      player_load <= 1'b0;
      dealer_load <= 1'b0;
      hands_clear <= 1'b0;

      case (st)
        S_IDLE, S_OVER: begin
          if (press_deal) begin
            st          <= S_CLEAR;
            hands_clear <= 1'b1;
            player_cnt  <= '0;
            dealer_cnt  <= '0;
            phase       <= 3'd1;
          end
        end

        S_CLEAR: begin
          st       <= S_REQ;
          slot     <= K_D1;
          card_req <= 1'b1;
        end

        S_REQ: begin
          if (card_ack) begin
            card_req <= 1'b0;
            card_out <= card_rank;
            st       <= S_LOAD;
            if (to_player) begin
              player_load <= 1'b1;
              if (player_cnt != CNT_MAX) player_cnt <= player_cnt + 3'd1;
            end else begin
              dealer_load <= 1'b1;
              if (dealer_cnt != CNT_MAX) dealer_cnt <= dealer_cnt + 3'd1;
            end
          end
        end

        S_LOAD: st <= S_SETTLE;

        // Sums are valid here; pick the return point for the card just loaded.
        S_SETTLE: begin
          case (slot)
            K_D1: begin slot <= K_D2; st <= S_REQ; card_req <= 1'b1; end
            K_D2: begin slot <= K_P1; st <= S_REQ; card_req <= 1'b1; end
            K_P1: begin slot <= K_P2; st <= S_REQ; card_req <= 1'b1; end
            K_P2: begin
              if (player_sum == 6'd21) begin
                st    <= S_OVER;
                phase <= 3'd4;
              end else begin
                st    <= S_PWAIT;
                phase <= 3'd2;
              end
            end
            K_PH:    st <= S_PWAIT;
            default: st <= S_DCHK;
          endcase
        end

        S_PWAIT: begin
          if (player_sum > 6'd21 || player_cnt == CNT_MAX) begin
            st    <= S_OVER;
            phase <= 3'd4;
          end else if (press_stand) begin
            st    <= S_DCHK;
            phase <= 3'd3;
          end else if (press_hit) begin
            slot     <= K_PH;
            st       <= S_REQ;
            card_req <= 1'b1;
          end
        end

        S_DCHK: begin
          if (dealer_sum < STAND_SUM && dealer_cnt < CNT_MAX) begin
            slot     <= K_DH;
            st       <= S_REQ;
            card_req <= 1'b1;
          end else begin
            st    <= S_OVER;
            phase <= 3'd4;
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
